// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one write port,
// optional zero register and write bypass, per-entry pending bits, clear sweep.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    output logic              a_pend,
    output logic              b_pend,
    input  logic              clear_req,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic [ADDR_W-1:0] r_cnt;

    logic              w_idle;
    logic              w_wr_en;
    logic              w_set_en;
    logic              w_zero_a;
    logic              w_zero_b;
    logic [DEPTH-1:0]  w_pend_next;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_zero_a = (ZERO_REG != 0) && (rs == '0);
    assign w_zero_b = (ZERO_REG != 0) && (rt == '0);

    // Writes and pending sets aimed at a hard-wired zero entry are dropped here.
    assign w_wr_en  = w_idle && RegWrite && !((ZERO_REG != 0) && (write_reg == '0));
    assign w_set_en = w_idle && pend_set && !((ZERO_REG != 0) && (pend_addr == '0));

    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        w_pend_next = r_pend;
        if (w_wr_en) begin
            w_pend_next[write_reg] = 1'b0;
        end
        if (w_set_en) begin
            w_pend_next[pend_addr] = 1'b1;
        end
    end

    always_comb begin
        a = r_mem[rs];
        if ((BYPASS != 0) && w_idle && RegWrite && (write_reg == rs)) begin
            a = write_data;
        end
        if (w_zero_a) begin
            a = '0;
        end
    end

    always_comb begin
        b = r_mem[rt];
        if ((BYPASS != 0) && w_idle && RegWrite && (write_reg == rt)) begin
            b = write_data;
        end
        if (w_zero_b) begin
            b = '0;
        end
    end

    // Pending flags are deliberately not bypassed: they show the stored bit.
    assign a_pend = w_zero_a ? 1'b0 : r_pend[rs];
    assign b_pend = w_zero_b ? 1'b0 : r_pend[rt];
    assign busy   = (r_state == ST_CLEAR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the array sits in the async reset because reset must zero every entry;
            // this keeps it in flops rather than an inferred RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_pend  <= '0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_en) begin
                        r_mem[write_reg] <= write_data;
                    end
                    if (clear_req) begin
                        r_pend  <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_CLEAR;
                    end else begin
                        r_pend <= w_pend_next;
                    end
                end
                ST_CLEAR: begin
                    r_mem[r_cnt] <= '0;
                    r_cnt        <= r_cnt + 1'b1;
                    if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: two instances (plain+bypass, zero-reg without bypass)
// share stimulus; expected outputs are queued by the driver and compared by a monitor.
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  rs, rt, write_reg, pend_addr;
    logic [31:0] write_data;
    logic        RegWrite, pend_set, clear_req;

    logic [31:0] a0, b0, a1, b1;
    logic        ap0, bp0, ap1, bp1, busy0, busy1;

    always #5 clk = ~clk;

    regfile_param #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u_dut0 (
        .clk(clk), .reset(reset), .rs(rs), .rt(rt), .a(a0), .b(b0),
        .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
        .pend_set(pend_set), .pend_addr(pend_addr), .a_pend(ap0), .b_pend(bp0),
        .clear_req(clear_req), .busy(busy0)
    );

    regfile_param #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) u_dut1 (
        .clk(clk), .reset(reset), .rs(rs), .rt(rt), .a(a1), .b(b1),
        .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
        .pend_set(pend_set), .pend_addr(pend_addr), .a_pend(ap1), .b_pend(bp1),
        .clear_req(clear_req), .busy(busy1)
    );

    typedef struct {
        string       tag;
        logic [31:0] a0, b0, a1, b1;
        logic        ap0, bp0, ap1, bp1, bsy;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: index 0 = plain instance with bypass, 1 = zero register, no bypass.
    logic [31:0] m_mem [2][8];
    logic        m_pend [2][8];
    int          m_left;   // sweep edges still to come; nonzero means busy

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 8; i++) begin
                m_mem[c][i]  = 32'h0;
                m_pend[c][i] = 1'b0;
            end
        end
        m_left = 0;
    endfunction

    function automatic logic [31:0] exp_rd(input int c, input logic [2:0] ad);
        if (c == 1 && ad == 3'd0) return 32'h0;
        if (c == 0 && m_left == 0 && RegWrite && write_reg == ad) return write_data;
        return m_mem[c][ad];
    endfunction

    function automatic logic exp_pd(input int c, input logic [2:0] ad);
        if (c == 1 && ad == 3'd0) return 1'b0;
        return m_pend[c][ad];
    endfunction

    function automatic void model_edge();
        if (!reset) begin
            model_reset();
            return;
        end
        if (m_left > 0) begin
            for (int c = 0; c < 2; c++) m_mem[c][8 - m_left] = 32'h0;
            m_left--;
            return;
        end
        for (int c = 0; c < 2; c++) begin
            if (RegWrite && !(c == 1 && write_reg == 3'd0)) begin
                m_mem[c][write_reg]  = write_data;
                m_pend[c][write_reg] = 1'b0;
            end
            if (pend_set && !(c == 1 && pend_addr == 3'd0)) m_pend[c][pend_addr] = 1'b1;
            if (clear_req) begin
                for (int i = 0; i < 8; i++) m_pend[c][i] = 1'b0;
            end
        end
        if (clear_req) m_left = 8;
    endfunction

    // Called at posedge+1 with inputs already driven; queues the expectation, then clocks once.
    task automatic cycle(input string tag);
        exp_t e;
        if (!reset) model_reset();
        e.tag = tag;
        e.a0  = exp_rd(0, rs);  e.b0  = exp_rd(0, rt);
        e.a1  = exp_rd(1, rs);  e.b1  = exp_rd(1, rt);
        e.ap0 = exp_pd(0, rs);  e.bp0 = exp_pd(0, rt);
        e.ap1 = exp_pd(1, rs);  e.bp1 = exp_pd(1, rt);
        e.bsy = (m_left > 0);
        sb_q.push_back(e);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        RegWrite   = 1'b0;
        pend_set   = 1'b0;
        clear_req  = 1'b0;
        write_reg  = 3'd0;
        write_data = 32'h0;
        pend_addr  = 3'd0;
    endtask

    task automatic wr(input logic [2:0] ad, input logic [31:0] d, input string tag);
        RegWrite   = 1'b1;
        write_reg  = ad;
        write_data = d;
        cycle(tag);
        RegWrite   = 1'b0;
    endtask

    task automatic fill(input logic [31:0] base);
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), base + 32'(i) * 32'h0101_0101 + 32'h1, "fill");
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check($sformatf("%s.a0", mon_e.tag), a0, mon_e.a0);
            check($sformatf("%s.b0", mon_e.tag), b0, mon_e.b0);
            check($sformatf("%s.a1", mon_e.tag), a1, mon_e.a1);
            check($sformatf("%s.b1", mon_e.tag), b1, mon_e.b1);
            check($sformatf("%s.a_pend0", mon_e.tag), 32'(ap0), 32'(mon_e.ap0));
            check($sformatf("%s.b_pend0", mon_e.tag), 32'(bp0), 32'(mon_e.bp0));
            check($sformatf("%s.a_pend1", mon_e.tag), 32'(ap1), 32'(mon_e.ap1));
            check($sformatf("%s.b_pend1", mon_e.tag), 32'(bp1), 32'(mon_e.bp1));
            check($sformatf("%s.busy0", mon_e.tag), 32'(busy0), 32'(mon_e.bsy));
            check($sformatf("%s.busy1", mon_e.tag), 32'(busy1), 32'(mon_e.bsy));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_idle();
        reset = 1'b0;
        rs = 3'd5;
        rt = 3'd3;
        model_reset();
        @(posedge clk);
        #1;

        cycle("reset");
        cycle("reset");
        reset = 1'b1;
        cycle("post_reset");

        // Write then read back; both ports were zero before the write.
        wr(3'd5, 32'hDEAD_BEEF, "wr5");
        cycle("rd5");

        // Same-cycle forwarding on the bypass instance only.
        rs = 3'd2;
        wr(3'd2, 32'h0000_1234, "bypass");
        cycle("bypass_next");

        // Zero register: write and pending mark on entry 0.
        rs = 3'd0;
        RegWrite = 1'b1; write_reg = 3'd0; write_data = 32'hFFFF_FFFF;
        pend_set = 1'b1; pend_addr = 3'd0;
        cycle("zero_wr");
        set_idle();
        cycle("zero_rd");

        // Scoreboard: set, simultaneous write+set, lone write.
        rs = 3'd4; rt = 3'd6;
        pend_set = 1'b1; pend_addr = 3'd4;
        cycle("pend_set");
        pend_set = 1'b0;
        cycle("pend_hold");
        RegWrite = 1'b1; write_reg = 3'd4; write_data = 32'h0000_4444;
        pend_set = 1'b1; pend_addr = 3'd4;
        cycle("pend_both");
        set_idle();
        cycle("pend_after_both");
        wr(3'd4, 32'h0000_5555, "pend_wr");
        cycle("pend_cleared");

        // Clear sweep with clear_req held and write attempts to entry 1 throughout.
        fill(32'h1000_0000);
        pend_set = 1'b1; pend_addr = 3'd6;
        cycle("pend6");
        pend_set = 1'b0;
        clear_req = 1'b1;
        cycle("clr_start");
        for (int k = 0; k < 8; k++) begin
            RegWrite = 1'b1; write_reg = 3'd1; write_data = 32'hAAAA_AAAA;
            rs = 3'(k); rt = 3'd1;
            cycle("sweep");
        end
        set_idle();
        for (int i = 0; i < 8; i++) begin
            rs = 3'(i); rt = 3'd6;
            cycle("post_sweep");
        end

        // Reset asserted mid-sweep without a clock edge.
        fill(32'h2000_0000);
        clear_req = 1'b1;
        cycle("clr2_start");
        clear_req = 1'b0;
        rs = 3'd7; rt = 3'd6;
        for (int k = 0; k < 3; k++) cycle("sweep2");
        reset = 1'b0;
        cycle("rst_mid");
        for (int i = 0; i < 4; i++) begin
            rs = 3'(2 * i); rt = 3'(2 * i + 1);
            cycle("rst_hold");
        end
        reset = 1'b1;
        fill(32'h3000_0000);
        clear_req = 1'b1;
        cycle("clr3_start");
        clear_req = 1'b0;
        for (int k = 0; k < 9; k++) begin
            rs = 3'(k); rt = 3'(7 - (k % 8));
            cycle("sweep3");
        end

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            rs         = 3'($urandom_range(7));
            rt         = 3'($urandom_range(7));
            RegWrite   = ($urandom_range(1) == 1);
            write_reg  = 3'($urandom_range(7));
            write_data = $urandom;
            pend_set   = ($urandom_range(2) == 0);
            pend_addr  = 3'($urandom_range(7));
            clear_req  = ($urandom_range(29) == 0);
            if ($urandom_range(3) == 0) write_reg = rs;
            cycle("random");
        end
        set_idle();

        for (int w = 0; w < 4 && sb_q.size() > 0; w++) @(negedge clk);
        if (sb_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised register file for the single-cycle datapath, replacing the fixed 8 x 32 register file. It provides two combinational read ports and one synchronous write port, with configurable width and depth. It adds an optional hard-wired zero register, write-to-read bypass, and a per-entry pending scoreboard so control can detect reads of registers awaiting a result. A multi-cycle clear sweep zeroes the array on request without asserting reset.

## Interface
- DATA_W, 32, data width of each entry
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes and pend_set
- BYPASS, 1, 1 = a write in the current cycle is forwarded to a matching read port

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; clears all entries, pending bits and FSM
- rs  in  ADDR_W  read address, port A
- rt  in  ADDR_W  read address, port B
- a  out  DATA_W  read data, port A
- b  out  DATA_W  read data, port B
- RegWrite  in  1  write enable
- write_reg  in  ADDR_W  write address
- write_data  in  DATA_W  write data
- pend_set  in  1  mark pend_addr as awaiting a write
- pend_addr  in  ADDR_W  entry to mark pending
- a_pend  out  1  pending bit of entry rs
- b_pend  out  1  pending bit of entry rt
- clear_req  in  1  start a clear sweep (one-cycle pulse or level)
- busy  out  1  clear sweep in progress

## Operation
- Storage: DEPTH x DATA_W array, plus a DEPTH-bit pending vector.
- Reset (reset=0, asynchronous):
  - All entries = 0 and all pending bits = 0.
  - FSM = IDLE, sweep counter = 0.
  - Outputs: a = b = 0, a_pend = b_pend = 0, busy = 0.
- Reads are combinational: a = mem[rs], b = mem[rt].
- Read override (applies to port A and, identically, port B):
  - If ZERO_REG=1 and rs==0: a = 0 and a_pend = 0.
  - Else, if BYPASS=1, state==IDLE, RegWrite=1 and write_reg==rs: a = write_data.
- Write: at the rising edge, if state==IDLE and RegWrite=1, mem[write_reg] <= write_data. The write is dropped if ZERO_REG=1 and write_reg==0.
- Scoreboard, per edge in IDLE:
  - A write to entry k clears pend[k].
  - pend_set sets pend[pend_addr].
  - If both hit the same entry, the set wins: the result is 1.
  - a_pend/b_pend are not bypassed; they show the registered bit.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clear_req=1.
    - That edge clears the whole pending vector and loads counter = 0.
    - A RegWrite in the same cycle is still performed.
  - In CLEAR, each edge writes mem[counter] <= 0 and increments counter.
  - After writing entry DEPTH-1, the state returns to IDLE and counter wraps to 0.
- Sweep length is exactly DEPTH cycles.
- During CLEAR:
  - RegWrite, pend_set and clear_req are ignored.
  - Reads return current array contents, which may be partly cleared.
  - busy=1.
- Address widths are exact, so no out-of-range addresses exist.

## Timing
- Read latency 0 (combinational from rs/rt/array).
- Write visible on a/b the cycle after the edge; with BYPASS=1 it is visible in the same cycle.
- busy rises the cycle after clear_req is sampled in IDLE.
- busy stays high for DEPTH cycles and falls on the edge that clears entry DEPTH-1.
- A clear_req sampled on that final edge is ignored. A new sweep needs clear_req high in a later IDLE cycle.
- Pending bit changes are visible on a_pend/b_pend one cycle after the edge.
- Reset asserted mid-sweep aborts immediately: the array is zeroed, busy=0 and the FSM returns to IDLE without waiting for a clock.
- Reset deassertion must be synchronised externally to clk. The first active edge is the first clk edge after deassertion.

## Test plan
- Reset then write/read:
  - Stimulus: reset low then high; write 0xDEADBEEF to entry 5; then rs=5, rt=3.
  - Required: a=0xDEADBEEF, b=0; both outputs were 0 before the write.
- Bypass:
  - Stimulus: BYPASS=1, RegWrite=1, write_reg=rs=2, write_data=0x1234.
  - Required: a=0x1234 in the same cycle. With BYPASS=0, a shows the old value until the next cycle.
- Zero register:
  - Stimulus: ZERO_REG=1, write 0xFFFFFFFF to entry 0, pend_set with pend_addr=0, rs=0.
  - Required: a=0, a_pend=0. Repeat with ZERO_REG=0: a=0xFFFFFFFF.
- Scoreboard:
  - Stimulus: pend_set on entry 4; a later write to entry 4 with pend_set on 4 in the same cycle; then a write to entry 4 alone.
  - Required: a_pend=1 after the first edge; still 1 after the simultaneous edge; 0 after the lone write.
- Clear sweep:
  - Stimulus: fill all 8 entries with nonzero data and set pend[6]; pulse clear_req; attempt a write to entry 1 during the sweep.
  - Required: busy high exactly 8 cycles; all entries read 0 afterwards; pend[6]=0; the entry-1 write is dropped.
- Reset mid-sweep:
  - Stimulus: assert reset at sweep cycle 3 with no clock edge.
  - Required: busy=0 and all entries 0 immediately; the next clear_req starts a full sweep again.
